// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code assembler: folds E0/F0/E1 prefix sequences into
// single key events and buffers them in a small FWFT FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 50000000,
  parameter int CNT_W          = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       received_data,
  input  logic             received_data_en,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_extended,
  output logic             evt_released,
  output logic             ctrl_seen,
  output logic [7:0]       ctrl_byte,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EXT_BRK, PAUSE
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] tcnt;
  logic [2:0]    pcnt;
  logic          stb;
  logic          is_e0, is_f0, is_e1, is_ctrl;
  logic          tmo, pause_done;
  logic          push_en, ctrl_hit, accept, pop;
  logic [9:0]    push_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign stb   = received_data_en;
  assign is_e0 = received_data == 8'hE0;
  assign is_f0 = received_data == 8'hF0;
  assign is_e1 = received_data == 8'hE1;

  always_comb begin
    is_ctrl = 1'b0;
    unique case (received_data)
      8'hFA, 8'hAA, 8'hEE, 8'hFE,
      8'hFC, 8'h00, 8'hFF: is_ctrl = 1'b1;
      default:             is_ctrl = 1'b0;
    endcase
  end

  // A strobe always beats the timeout in the same cycle.
  assign tmo = (state != IDLE) && !stb &&
               (tcnt == TW'(PREFIX_TIMEOUT - 1));
  assign pause_done = (state == PAUSE) && stb && (pcnt == 3'd1);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (stb) begin
          unique case (1'b1)
            is_e0:   state_nxt = EXT;
            is_f0:   state_nxt = BRK;
            is_e1:   state_nxt = PAUSE;
            default: state_nxt = IDLE;
          endcase
        end
      end
      EXT: begin
        if (stb) begin
          if (is_f0)       state_nxt = EXT_BRK;
          else if (!is_e0) state_nxt = IDLE;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      BRK, EXT_BRK: begin
        if (stb || tmo) state_nxt = IDLE;
      end
      PAUSE: begin
        if (pause_done || tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push_en   = 1'b0;
    push_data = {2'b00, received_data};
    ctrl_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (stb && !is_e0 && !is_f0 && !is_e1) begin
          ctrl_hit = is_ctrl;
          push_en  = !is_ctrl;
        end
      end
      EXT: begin
        push_en   = stb && !is_f0 && !is_e0;
        push_data = {2'b10, received_data};
      end
      BRK: begin
        push_en   = stb;
        push_data = {2'b01, received_data};
      end
      EXT_BRK: begin
        push_en   = stb;
        push_data = {2'b11, received_data};
      end
      PAUSE: begin
        push_en   = pause_done;
        push_data = {2'b00, 8'hE1};
      end
      default: push_en = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      pcnt <= '0;
    end else begin
      if (stb || tmo || state == IDLE) tcnt <= '0;
      else                             tcnt <= tcnt + TW'(1);
      if (state == IDLE && stb && is_e1) pcnt <= 3'd7;
      else if (state == PAUSE && stb)    pcnt <= pcnt - 3'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ctrl_seen <= 1'b0;
      ctrl_byte <= '0;
    end else begin
      ctrl_seen <= ctrl_hit;
      if (ctrl_hit) ctrl_byte <= received_data;
    end
  end

  assign evt_valid = fifo_count != '0;
  assign pop       = evt_valid && evt_ready;
  assign accept    = push_en &&
                     ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push_en && !accept) overflow <= 1'b1;
    end
  end

  assign {evt_extended, evt_released, evt_code} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: expected events queued at
// stimulus time, compared in order as the DUT pops them.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;
  localparam int PT    = 20;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data;
  logic          en;
  logic          rdy;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_extended;
  logic          evt_released;
  logic          ctrl_seen;
  logic [7:0]    ctrl_byte;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  logic [9:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  ps2_scancode_decoder #(
    .FIFO_DEPTH(DEPTH),
    .PREFIX_TIMEOUT(PT),
    .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .received_data(data),
    .received_data_en(en),
    .evt_ready(rdy),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_extended(evt_extended),
    .evt_released(evt_released),
    .ctrl_seen(ctrl_seen),
    .ctrl_byte(ctrl_byte),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int n);
    rdy = 1'b1;
    idle(n);
    rdy = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && evt_valid && rdy) begin
      if (exp_q.size() == 0)
        check("sb_extra", 32'(evt_code), 32'hFFFF);
      else
        check("sb_evt",
              32'({evt_extended, evt_released, evt_code}),
              32'(exp_q.pop_front()));
    end
  end

  initial begin
    rst  = 1'b1;
    data = '0;
    en   = 1'b0;
    rdy  = 1'b0;
    idle(3);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_code", 32'(evt_code), 0);
    check("rst_ext", 32'(evt_extended), 0);
    check("rst_rel", 32'(evt_released), 0);
    check("rst_ctrl_seen", 32'(ctrl_seen), 0);
    check("rst_ctrl_byte", 32'(ctrl_byte), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_count", 32'(fifo_count), 0);
    rst = 1'b0;
    idle(1);

    // plain make code
    send(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_code", 32'(evt_code), 32'h1C);
    check("t1_count", 32'(fifo_count), 1);
    drain(1);
    check("t1_count_pop", 32'(fifo_count), 0);
    check("t1_valid_pop", 32'(evt_valid), 0);

    // extended break
    send(8'hE0);
    check("t2_e0_cnt", 32'(fifo_count), 0);
    send(8'hF0);
    check("t2_f0_cnt", 32'(fifo_count), 0);
    send(8'h75);
    exp_q.push_back({2'b11, 8'h75});
    check("t2_count", 32'(fifo_count), 1);
    check("t2_ext", 32'(evt_extended), 1);
    check("t2_rel", 32'(evt_released), 1);
    drain(2);

    // pause/break sequence, then a plain make
    begin
      logic [7:0] seq [8];
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
              8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 7; i++) send(seq[i]);
      check("t3_pre_cnt", 32'(fifo_count), 0);
      send(seq[7]);
      exp_q.push_back({2'b00, 8'hE1});
      check("t3_cnt", 32'(fifo_count), 1);
      check("t3_code", 32'(evt_code), 32'hE1);
    end
    send(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    check("t3_cnt2", 32'(fifo_count), 2);
    drain(3);

    // control responses
    send(8'hFA);
    check("t4_seen1", 32'(ctrl_seen), 1);
    check("t4_byte1", 32'(ctrl_byte), 32'hFA);
    idle(1);
    check("t4_seen_lo", 32'(ctrl_seen), 0);
    send(8'hAA);
    check("t4_seen2", 32'(ctrl_seen), 1);
    check("t4_byte2", 32'(ctrl_byte), 32'hAA);
    check("t4_count", 32'(fifo_count), 0);

    // overflow, then push+pop while full
    for (int i = 1; i <= 5; i++) begin
      send(8'(i));
      if (i <= DEPTH) exp_q.push_back({2'b00, 8'(i)});
    end
    check("t5_count", 32'(fifo_count), DEPTH);
    check("t5_ovf", 32'(overflow), 1);
    data = 8'h06;
    en   = 1'b1;
    rdy  = 1'b1;
    exp_q.push_back({2'b00, 8'h06});
    @(posedge clk);
    #1;
    en  = 1'b0;
    rdy = 1'b0;
    check("t5_full_pp_cnt", 32'(fifo_count), DEPTH);
    check("t5_full_pp_ovf", 32'(overflow), 1);
    drain(6);
    check("t5_drained", 32'(fifo_count), 0);

    // BRK abandoned by timeout, then BRK completed just inside it
    send(8'hF0);
    idle(PT + 2);
    send(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    check("t6_tmo_rel", 32'(evt_released), 0);
    drain(2);
    send(8'hF0);
    idle(PT - 3);
    send(8'h1C);
    exp_q.push_back({2'b01, 8'h1C});
    check("t6_in_rel", 32'(evt_released), 1);
    drain(2);

    // reset while in EXT_BRK with a queued event
    send(8'h33);
    send(8'hE0);
    send(8'hF0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #3;
    check("t7_valid", 32'(evt_valid), 0);
    check("t7_count", 32'(fifo_count), 0);
    check("t7_ovf", 32'(overflow), 0);
    check("t7_code", 32'(evt_code), 0);
    check("t7_flags", 32'({evt_extended, evt_released}), 0);
    check("t7_ctrl", 32'({ctrl_seen, ctrl_byte}), 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    send(8'h1C);
    exp_q.push_back({2'b00, 8'h1C});
    check("t7_code_after", 32'(evt_code), 32'h1C);
    check("t7_flags_after", 32'({evt_extended, evt_released}), 0);
    drain(2);

    check("sb_left", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes the byte stream from the PS/2 controller (received_data / received_data_en) and assembles multi-byte Set-2 scan-code sequences into single key events. Each event carries a code, an extended flag and a released flag. Device control responses are filtered out and reported separately. Events are buffered in a small FIFO with a valid/ready output so downstream logic (display, keyboard-state tracker) can stall without losing keystrokes.

Parameters:
FIFO_DEPTH, 4, number of buffered events; power of 2, 2..16
PREFIX_TIMEOUT, 50000000, CLOCK_50 cycles allowed between a prefix byte (E0/F0/E1 sequence) and its follow-on byte before the FSM abandons it
CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
received_data  input  8  byte from PS/2 controller
received_data_en  input  1  one-cycle strobe; received_data valid this cycle
evt_ready  input  1  downstream accepts head event this cycle
evt_valid  output  1  FIFO non-empty; head event presented
evt_code  output  8  scan code of head event (prefixes stripped)
evt_extended  output  1  head event was E0-prefixed
evt_released  output  1  head event was F0-prefixed (break)
ctrl_seen  output  1  one-cycle pulse: control byte received in IDLE
ctrl_byte  output  8  last control byte received, held until next
overflow  output  1  sticky: an event was dropped because FIFO full
fifo_count  output  CNT_W  number of events held

Behaviour:
- Reset (async assert, sync use on next edge after deassert): FSM=IDLE, FIFO empty, timeout counter 0, pause counter 0. Outputs: evt_valid=0, evt_code=0, evt_extended=0, evt_released=0, ctrl_seen=0, ctrl_byte=0, overflow=0, fifo_count=0.
- Bytes are processed only in cycles with received_data_en=1. One byte per strobe; back-to-back strobes are legal.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE transitions:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE, pause counter=7.
  - FA, AA, EE, FE, FC, 00, FF -> stay IDLE, ctrl_byte<=byte, ctrl_seen=1 next cycle.
  - Any other byte -> push {ext=0, rel=0, code}.
- EXT: F0 -> EXT_BRK; E0 -> stay EXT (repeat prefix ignored); other -> push {1,0,code}, -> IDLE.
- BRK: any byte -> push {0,1,code}, -> IDLE. This includes codes equal to prefix values; F0 after F0 pushes code F0.
- EXT_BRK: any byte -> push {1,1,code}, -> IDLE.
- PAUSE: each strobe decrements the counter and the byte is discarded. When the counter reaches 0, push {0,0,E1} and go to IDLE. Pause Break yields exactly one event.
- Timeout: in EXT, BRK, EXT_BRK or PAUSE, the counter increments every cycle without a strobe and clears on each strobe. At PREFIX_TIMEOUT-1 the FSM returns to IDLE, nothing is pushed, and the counter is cleared. A strobe in the same cycle as the timeout wins: the byte is processed normally.
- Timing: event complete on strobe in cycle N -> entry written at edge ending N -> evt_valid=1 in N+1 (if FIFO was empty). ctrl_seen is high in N+1 only.
- FIFO:
  - Entry = {extended, released, code}, 10 bits; first-word-fall-through.
  - evt_* reflect the head whenever evt_valid=1.
  - Pop when evt_valid & evt_ready.
  - Push accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the event is dropped and overflow<=1 until reset.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count reflects net push/pop: simultaneous push and pop leaves it unchanged.
- evt_code/flags hold their last head value when empty; not guaranteed meaningful while evt_valid=0.

Test Plan:
- Reset then strobe 1C -> evt_valid=1 one cycle later, code=1C, ext=0, rel=0, fifo_count=1; evt_ready=1 -> count 0, evt_valid=0.
- Strobes E0, F0, 75 with evt_ready=0 -> single event code=75, ext=1, rel=1; intermediate bytes create no events.
- Strobes E1 14 77 E1 F0 14 F0 77 -> exactly one event code=E1, ext=0, rel=0; FSM back in IDLE (next 1C gives plain event).
- Strobe FA, then AA -> ctrl_seen pulses twice, ctrl_byte=FA then AA, fifo_count stays 0.
- evt_ready=0, push 5 events with FIFO_DEPTH=4 -> count=4, overflow=1, first 4 codes pop in order; then full FIFO with simultaneous push+pop -> push accepted, count stays 4, overflow unchanged.
- Strobe F0, wait PREFIX_TIMEOUT cycles, strobe 1C -> event rel=0 (prefix abandoned). Separately, assert reset mid-EXT_BRK -> all outputs 0, next byte decoded from IDLE.
